// File: rtl/nibble_link_host_if.sv
// Bus bundle between the nibble_link_host and its environment: command handshake,
// serial TX toward the wrapper, strobed RX from the wrapper and the response port.
interface nibble_link_host_if #(
    parameter int NIBBLE_W = 4,
    parameter int WORD_W   = 32
);
    logic [WORD_W-1:0]   cmd_data;
    logic                cmd_dir;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [NIBBLE_W-1:0] tx_nibble;
    logic                tx_dir;
    logic                tx_frame_start;
    logic                tx_active;
    logic [NIBBLE_W-1:0] rx_nibble;
    logic                rx_strobe;
    logic [WORD_W-1:0]   rsp_data;
    logic                rsp_valid;
    logic                rsp_overrun;

    // master: command source plus the wrapper's return path; slave: the link host itself
    modport master (
        output cmd_data, cmd_dir, cmd_valid, rx_nibble, rx_strobe,
        input  cmd_ready, tx_nibble, tx_dir, tx_frame_start, tx_active,
        input  rsp_data, rsp_valid, rsp_overrun
    );

    modport slave (
        input  cmd_data, cmd_dir, cmd_valid, rx_nibble, rx_strobe,
        output cmd_ready, tx_nibble, tx_dir, tx_frame_start, tx_active,
        output rsp_data, rsp_valid, rsp_overrun
    );
endinterface

// File: rtl/nibble_link_host.sv
// Host-side peer of the nibble-serial wrapper: serialises 32-bit commands MSB nibble
// first into back-to-back frames and reassembles strobed nibble responses.
module nibble_link_host #(
    parameter int NIBBLE_W = 4,
    parameter int WORD_W   = 32,
    parameter int RX_DUP   = 1
) (
    input logic               sys_clk,
    input logic               rst,
    nibble_link_host_if.slave bus
);
    localparam int SLOTS  = WORD_W / NIBBLE_W;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int SKIP_W = (RX_DUP > 1) ? $clog2(RX_DUP + 1) : 1;
    localparam int PART_W = WORD_W - NIBBLE_W;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_WAIT, RX_SKIP, RX_COLLECT} rx_state_t;

    tx_state_t           tx_state_reg;
    logic [SLOT_W-1:0]   slot_reg;
    logic [WORD_W-1:0]   tx_shift_reg;
    logic [NIBBLE_W-1:0] tx_nibble_reg;
    logic                tx_dir_reg;
    logic                tx_frame_start_reg;
    logic                tx_active_reg;
    logic                last_slot;
    logic                cmd_ready_int;
    logic                cmd_fire;

    // Ready during the final slot lets the next frame start with zero gap cycles
    assign last_slot     = (slot_reg == SLOT_W'(SLOTS - 1));
    assign cmd_ready_int = (tx_state_reg == TX_IDLE) || ((tx_state_reg == TX_SEND) && last_slot);
    assign cmd_fire      = bus.cmd_valid && cmd_ready_int;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_state_reg       <= TX_IDLE;
            slot_reg           <= '0;
            tx_shift_reg       <= '0;
            tx_nibble_reg      <= '0;
            tx_dir_reg         <= 1'b0;
            tx_frame_start_reg <= 1'b0;
            tx_active_reg      <= 1'b0;
        end else if (cmd_fire) begin
            // Slot 0 goes out straight from cmd_data; the shifter keeps the remaining nibbles
            tx_state_reg       <= TX_SEND;
            slot_reg           <= '0;
            tx_shift_reg       <= bus.cmd_data << NIBBLE_W;
            tx_nibble_reg      <= bus.cmd_data[WORD_W-1 -: NIBBLE_W];
            tx_dir_reg         <= bus.cmd_dir;
            tx_frame_start_reg <= 1'b1;
            tx_active_reg      <= 1'b1;
        end else if (tx_state_reg == TX_SEND) begin
            tx_frame_start_reg <= 1'b0;
            if (last_slot) begin
                tx_state_reg  <= TX_IDLE;
                slot_reg      <= '0;
                tx_nibble_reg <= '0;
                tx_active_reg <= 1'b0;
            end else begin
                slot_reg      <= slot_reg + SLOT_W'(1);
                tx_nibble_reg <= tx_shift_reg[WORD_W-1 -: NIBBLE_W];
                tx_shift_reg  <= tx_shift_reg << NIBBLE_W;
            end
        end
    end

    assign bus.cmd_ready      = cmd_ready_int;
    assign bus.tx_nibble      = tx_nibble_reg;
    assign bus.tx_dir         = tx_dir_reg;
    assign bus.tx_frame_start = tx_frame_start_reg;
    assign bus.tx_active      = tx_active_reg;

    rx_state_t         rx_state_reg;
    logic [PART_W-1:0] rx_word_reg;
    logic [SLOT_W-1:0] nib_cnt_reg;
    logic [SKIP_W-1:0] skip_cnt_reg;
    logic [WORD_W-1:0] rsp_data_reg;
    logic              rsp_valid_reg;
    logic              rsp_overrun_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_state_reg    <= RX_WAIT;
            rx_word_reg     <= '0;
            nib_cnt_reg     <= '0;
            skip_cnt_reg    <= '0;
            rsp_data_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_overrun_reg <= 1'b0;
        end else begin
            rsp_valid_reg   <= 1'b0;
            rsp_overrun_reg <= 1'b0;
            if (bus.rx_strobe) begin
                // A strobe always restarts capture; it only counts as overrun if one was in flight
                if (rx_state_reg != RX_WAIT) rsp_overrun_reg <= 1'b1;
                rx_word_reg  <= PART_W'(bus.rx_nibble);
                nib_cnt_reg  <= '0;
                skip_cnt_reg <= SKIP_W'(RX_DUP);
                rx_state_reg <= (RX_DUP == 0) ? RX_COLLECT : RX_SKIP;
            end else begin
                case (rx_state_reg)
                    RX_SKIP: begin
                        if (skip_cnt_reg == SKIP_W'(1)) rx_state_reg <= RX_COLLECT;
                        skip_cnt_reg <= skip_cnt_reg - SKIP_W'(1);
                    end
                    RX_COLLECT: begin
                        rx_word_reg <= {rx_word_reg[PART_W-NIBBLE_W-1:0], bus.rx_nibble};
                        nib_cnt_reg <= nib_cnt_reg + SLOT_W'(1);
                        if (nib_cnt_reg == SLOT_W'(SLOTS - 2)) begin
                            rsp_data_reg  <= {rx_word_reg, bus.rx_nibble};
                            rsp_valid_reg <= 1'b1;
                            rx_state_reg  <= RX_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rsp_data    = rsp_data_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_overrun = rsp_overrun_reg;
endmodule

// File: tb/tb_nibble_link_host.sv
// Directed plus randomized bench for nibble_link_host, checked every cycle against a
// slot-queue model of the TX frames and a nibble-list model of the RX responses.
module tb_nibble_link_host;
    localparam int NW     = 4;
    localparam int WW     = 32;
    localparam int RX_DUP = 1;
    localparam int SLOTS  = WW / NW;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    nibble_link_host_if #(.NIBBLE_W(NW), .WORD_W(WW)) bus ();

    nibble_link_host #(.NIBBLE_W(NW), .WORD_W(WW), .RX_DUP(RX_DUP)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [3:0] nib;
        logic       dir;
        logic       start;
    } slot_t;

    slot_t       txq[$];
    logic        model_dir;
    int          cap_len;
    logic [3:0]  nibs[$];
    logic [31:0] exp_rsp;
    logic        exp_valid, exp_ovr;
    bit          last_hs;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs sampled at this edge, then check all outputs
    task automatic cycle();
        bit          hs;
        logic [31:0] w;
        hs        = !rst && bus.cmd_valid && (txq.size() <= 1);
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        if (rst) begin
            txq.delete();
            nibs.delete();
            model_dir = 1'b0;
            cap_len   = 0;
            exp_rsp   = '0;
        end else begin
            if (txq.size() > 0) void'(txq.pop_front());
            if (hs) begin
                for (int k = 0; k < SLOTS; k++)
                    txq.push_back('{bus.cmd_data[31-4*k -: 4], bus.cmd_dir, (k == 0)});
                $display("cmd  data=%h dir=%b", bus.cmd_data, bus.cmd_dir);
            end
            if (bus.rx_strobe) begin
                if (cap_len > 0) exp_ovr = 1'b1;
                nibs.delete();
                nibs.push_back(bus.rx_nibble);
                cap_len = 1;
            end else if (cap_len > 0) begin
                if (cap_len > RX_DUP) nibs.push_back(bus.rx_nibble);
                cap_len++;
                if (nibs.size() == SLOTS) begin
                    w = '0;
                    for (int i = 0; i < SLOTS; i++) w = (w << 4) | 32'(nibs[i]);
                    exp_rsp   = w;
                    exp_valid = 1'b1;
                    cap_len   = 0;
                    $display("rsp  data=%h", w);
                end
            end
        end
        last_hs = hs;
        @(posedge sys_clk);
        #1;
        if (txq.size() > 0) model_dir = txq[0].dir;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(txq.size() <= 1));
        chk("tx_active", 32'(bus.tx_active), 32'(txq.size() > 0));
        chk("tx_nibble", 32'(bus.tx_nibble), (txq.size() > 0) ? 32'(txq[0].nib) : 32'd0);
        chk("tx_frame_start", 32'(bus.tx_frame_start), (txq.size() > 0) ? 32'(txq[0].start) : 32'd0);
        chk("tx_dir", 32'(bus.tx_dir), 32'(model_dir));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        chk("rsp_overrun", 32'(bus.rsp_overrun), 32'(exp_ovr));
        chk("rsp_data", bus.rsp_data, exp_rsp);
    endtask

    task automatic rsp_begin(input logic [31:0] w);
        bus.rx_strobe = 1'b1;
        bus.rx_nibble = w[31:28];
        cycle();
        bus.rx_strobe = 1'b0;
    endtask

    task automatic rsp_rest(input logic [31:0] w);
        for (int d = 0; d < RX_DUP; d++) cycle();
        for (int i = 1; i < SLOTS; i++) begin
            bus.rx_nibble = w[31-4*i -: 4];
            cycle();
        end
        bus.rx_nibble = '0;
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] w1;
        int          n;
        model_dir     = 1'b0;
        cap_len       = 0;
        exp_rsp       = '0;
        rst           = 1'b1;
        bus.cmd_data  = '0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rx_nibble = '0;
        bus.rx_strobe = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // T2: single command, nibbles MSB first
        bus.cmd_data  = 32'h1234_ABCD;
        bus.cmd_dir   = 1'b1;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 32'h5555_5555;
        obs = {28'd0, bus.tx_nibble};
        for (int k = 1; k < SLOTS; k++) begin
            cycle();
            obs = (obs << 4) | 32'(bus.tx_nibble);
        end
        chk("t2_word", obs, 32'h1234_ABCD);
        cycle();
        chk("t2_idle", 32'(bus.tx_active), 32'd0);

        // T1: reset mid-frame and mid-response
        bus.cmd_data  = $urandom;
        bus.cmd_dir   = 1'b1;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        rsp_begin($urandom);
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("t1_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t1_active", 32'(bus.tx_active), 32'd0);
        for (int i = 0; i < 10; i++) cycle();

        // T3: back-to-back frames with valid held high
        bus.cmd_data  = 32'h0000_0032;
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_data = 32'hFFFF_FFFF;
        bus.cmd_dir  = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_hs && n < 12);
        bus.cmd_valid = 1'b0;
        chk("t3_gap_cycles", 32'(n), 32'd8);
        chk("t3_frame2_start", 32'(bus.tx_frame_start), 32'd1);
        chk("t3_frame2_dir", 32'(bus.tx_dir), 32'd1);
        for (int i = 0; i < 9; i++) cycle();

        // T4: response 0x0000_002A
        rsp_begin(32'h0000_002A);
        rsp_rest(32'h0000_002A);
        chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t4_data", bus.rsp_data, 32'h0000_002A);
        cycle();

        // T5: new strobe four cycles into a response
        w1 = $urandom;
        rsp_begin(w1);
        for (int i = 0; i < 3; i++) begin
            bus.rx_nibble = $urandom;
            cycle();
        end
        w1 = $urandom;
        rsp_begin(w1);
        chk("t5_overrun", 32'(bus.rsp_overrun), 32'd1);
        chk("t5_old_data", bus.rsp_data, 32'h0000_002A);
        rsp_rest(w1);
        chk("t5_new_data", bus.rsp_data, w1);
        cycle();

        // T6: handshake and strobe on the same cycle while a frame is in flight
        bus.cmd_data  = $urandom;
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_data = $urandom;
        bus.cmd_dir  = 1'b1;
        n = 0;
        while (txq.size() != 1 && n < 10) begin
            cycle();
            n++;
        end
        w1 = $urandom;
        rsp_begin(w1);
        bus.cmd_valid = 1'b0;
        chk("t6_frame_start", 32'(bus.tx_frame_start), 32'd1);
        rsp_rest(w1);
        chk("t6_rsp", bus.rsp_data, w1);
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic on both paths with occasional resets
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_data  = $urandom;
            bus.cmd_dir   = 1'($urandom);
            bus.rx_strobe = ($urandom_range(0, 9) == 0);
            bus.rx_nibble = 4'($urandom);
            rst           = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rx_strobe = 1'b0;
        for (int i = 0; i < 12; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
